// File: rtl/timer_prescaler.sv
// timer_prescaler
// Produces the single-cycle count-enable pulse for the 64-bit timer counter.
// Divides the system clock by 2^div_val (clamped to MAX_DIV_VAL) when division
// is enabled, passes every cycle through when it is not, and freezes counting
// while the CPU is halted in debug mode. Any change to the division settings
// restarts the prescale period so the counter never sees a short first period.
// INT_CNT_WIDTH is expected to equal MAX_DIV_VAL so the largest limit fits.

module timer_prescaler #(
    parameter int DIV_WIDTH     = 4,
    parameter int MAX_DIV_VAL   = 8,
    parameter int INT_CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 timer_en,
    input  logic                 div_en,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 dbg_mode,
    input  logic                 halt_req,
    output logic                 cnt_en,
    output logic                 halt_ack
);

    localparam logic [DIV_WIDTH-1:0]     MAX_DIV  = DIV_WIDTH'(MAX_DIV_VAL);
    localparam logic [INT_CNT_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [INT_CNT_WIDTH-1:0] CNT_ONE  = INT_CNT_WIDTH'(1);

    logic [DIV_WIDTH-1:0]     w_effDiv;
    logic [INT_CNT_WIDTH-1:0] w_limit;
    logic                     w_halted;
    logic                     w_active;
    logic                     w_cfgChg;
    logic                     w_atLimit;

    logic [INT_CNT_WIDTH-1:0] r_intCnt;
    logic                     r_divEnQ;
    logic [DIV_WIDTH-1:0]     r_divValQ;
    logic                     r_haltAck;

    // Clamp the exponent, derive the wrap limit, and detect halt / config changes
    always_comb begin
        w_effDiv  = (div_val > MAX_DIV) ? MAX_DIV : div_val;
        w_limit   = ~(ALL_ONES << w_effDiv);
        w_halted  = dbg_mode & halt_req;
        w_active  = timer_en & ~w_halted;
        w_cfgChg  = (div_en != r_divEnQ) || (w_effDiv != r_divValQ);
        w_atLimit = (r_intCnt == w_limit);
    end

    // Count enable: suppressed on config change or when inactive, otherwise every
    // cycle undivided or once per wrap of the prescale counter when dividing
    always_comb begin
        cnt_en = w_active & ~w_cfgChg & (~div_en | w_atLimit);
    end

    assign halt_ack = r_haltAck;

    // Remember the last configuration so a change can restart the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divEnQ  <= 1'b0;
            r_divValQ <= '0;
            r_haltAck <= 1'b0;
        end else begin
            r_divEnQ  <= div_en;
            r_divValQ <= w_effDiv;
            r_haltAck <= w_halted;
        end
    end

    // Prescale counter: disable and config change clear it, halt freezes it so
    // the phase survives a debug stop, otherwise it wraps at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intCnt <= '0;
        end else if (!timer_en) begin
            r_intCnt <= '0;
        end else if (w_cfgChg) begin
            r_intCnt <= '0;
        end else if (w_halted) begin
            r_intCnt <= r_intCnt;
        end else if (!div_en) begin
            r_intCnt <= '0;
        end else if (w_atLimit) begin
            r_intCnt <= '0;
        end else begin
            r_intCnt <= r_intCnt + CNT_ONE;
        end
    end

endmodule
